// File: rtl/des_pkg.sv
// DES key-schedule constants: widths, FSM states, per-round shift amounts, PC-2 table.
// Optional macro DES_KEYSCHED_DECRYPT_EN adds the right-rotate helper for reverse-order schedules.
package des_pkg;

  localparam int HALF_W   = 28;
  localparam int SUBKEY_W = 48;
  localparam int KEY_W    = 56;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [1:0] SHIFTS [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // Entry j gives the 1-based C/D bit (1 = MSB) feeding subkey bit j+1.
  localparam int PC2_TAB [SUBKEY_W] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic logic [KEY_W-1:0] rotl_cd(input logic [KEY_W-1:0] cd, input logic [1:0] n);
    logic [HALF_W-1:0] c;
    logic [HALF_W-1:0] d;
    c = cd[55:28];
    d = cd[27:0];
    if (n == 2'd2) begin
      c = {c[25:0], c[27:26]};
      d = {d[25:0], d[27:26]};
    end else begin
      c = {c[26:0], c[27]};
      d = {d[26:0], d[27]};
    end
    return {c, d};
  endfunction

`ifdef DES_KEYSCHED_DECRYPT_EN
  function automatic logic [KEY_W-1:0] rotr_cd(input logic [KEY_W-1:0] cd, input logic [1:0] n);
    logic [HALF_W-1:0] c;
    logic [HALF_W-1:0] d;
    c = cd[55:28];
    d = cd[27:0];
    if (n == 2'd2) begin
      c = {c[1:0], c[27:2]};
      d = {d[1:0], d[27:2]};
    end else begin
      c = {c[0], c[27:1]};
      d = {d[0], d[27:1]};
    end
    return {c, d};
  endfunction
`endif

endpackage

// File: rtl/des_key_schedule_pc2.sv
// PC-2 permuted choice: purely combinational 56-bit C/D to 48-bit round key, MSB = PC-2 bit 1.
module pc2 import des_pkg::*; (
  input  logic [KEY_W-1:0]    cd_i,
  output logic [SUBKEY_W-1:0] subkey_o
);

  always_comb begin
    subkey_o = '0;
    for (int j = 0; j < SUBKEY_W; j++) begin
      subkey_o[SUBKEY_W-1-j] = cd_i[KEY_W - PC2_TAB[j]];
    end
  end

endmodule

// File: rtl/des_key_schedule.sv
// DES round-key generator: issues 16 PC-2 subkeys over a valid/ready handshake, then pulses done.
// DES_KEYSCHED_DECRYPT_EN adds the decrypt input for reverse (K16..K1) order.
module des_key_schedule import des_pkg::*; (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [KEY_W-1:0]    key_in,
`ifdef DES_KEYSCHED_DECRYPT_EN
  input  logic                decrypt,
`endif
  output logic                busy,
  output logic                subkey_valid,
  input  logic                subkey_ready,
  output logic [SUBKEY_W-1:0] subkey,
  output logic [3:0]          round,
  output logic                done
);

  state_t             state_q, state_d;
  logic [KEY_W-1:0]   cd_q, cd_d;
  logic [3:0]         round_q, round_d;
  logic [SUBKEY_W-1:0] pc2_out;
  logic               accept, hs;

  assign accept = (state_q == IDLE) && start;
  assign hs     = (state_q == RUN) && subkey_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (hs && round_q == 4'd15) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state_q != IDLE);
    subkey_valid = (state_q == RUN);
    done         = (state_q == FIN);
    subkey       = subkey_valid ? pc2_out : '0;
    round        = round_q;
  end

`ifdef DES_KEYSCHED_DECRYPT_EN
  logic dec_q, dec_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dec_q <= 1'b0;
    else        dec_q <= dec_d;
  end

  // Decrypt starts from C0/D0 (== C16/D16) and undoes each encrypt shift in reverse.
  always_comb begin
    cd_d    = cd_q;
    round_d = round_q;
    dec_d   = dec_q;
    if (accept) begin
      round_d = 4'd0;
      dec_d   = decrypt;
      cd_d    = decrypt ? key_in : rotl_cd(key_in, SHIFTS[0]);
    end else if (hs) begin
      round_d = round_q + 4'd1;
      if (dec_q) cd_d = rotr_cd(cd_q, SHIFTS[4'd15 - round_q]);
      else       cd_d = rotl_cd(cd_q, SHIFTS[round_q + 4'd1]);
    end
  end
`else
  // C/D always holds the pair for the key currently presented; round wraps to 0 after K16.
  always_comb begin
    cd_d    = cd_q;
    round_d = round_q;
    if (accept) begin
      round_d = 4'd0;
      cd_d    = rotl_cd(key_in, SHIFTS[0]);
    end else if (hs) begin
      round_d = round_q + 4'd1;
      cd_d    = rotl_cd(cd_q, SHIFTS[round_q + 4'd1]);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cd_q    <= '0;
      round_q <= 4'd0;
    end else begin
      cd_q    <= cd_d;
      round_q <= round_d;
    end
  end

  pc2 u_pc2 (
    .cd_i     (cd_q),
    .subkey_o (pc2_out)
  );

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule using the classic 133457799BBCDFF1 key (PC-1 form F0CCAAF556678F).
module tb_des_key_schedule;

  localparam logic [55:0] KEY = 56'hF0CCAAF556678F;
  localparam logic [47:0] KEYS [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [55:0] key_in;
  logic        busy, subkey_valid, subkey_ready, done;
  logic [47:0] subkey;
  logic [3:0]  round;
`ifdef DES_KEYSCHED_DECRYPT_EN
  logic        decrypt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  des_key_schedule dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .key_in       (key_in),
`ifdef DES_KEYSCHED_DECRYPT_EN
    .decrypt      (decrypt),
`endif
    .busy         (busy),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready),
    .subkey       (subkey),
    .round        (round),
    .done         (done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // mode 0: table key, 1: all-zero key, 2: all-one key
  function automatic logic [47:0] exp_key(input int mode, input bit dec, input int idx);
    int k;
    k = dec ? (15 - (idx & 15)) : (idx & 15);
    if (mode == 1) return 48'h0;
    if (mode == 2) return 48'hFFFFFFFFFFFF;
    return KEYS[k];
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"},   64'(busy),         64'd0);
    check({tag, "_valid"},  64'(subkey_valid), 64'd0);
    check({tag, "_done"},   64'(done),         64'd0);
    check({tag, "_subkey"}, 64'(subkey),       64'd0);
    check({tag, "_round"},  64'(round),        64'd0);
  endtask

  task automatic run_sched(input logic [55:0] key, input int mode, input bit dec,
                           input bit rand_ready, input bit poke);
    int idx;
    int edges;
    bit hs;
    bit seen_done;
    @(negedge clk);
    key_in = key;
    start  = 1'b1;
    subkey_ready = 1'b1;
`ifdef DES_KEYSCHED_DECRYPT_EN
    decrypt = dec;
`endif
    @(negedge clk);
    start  = 1'b0;
    key_in = ~key;
    edges = 1;
    idx = 0;
    seen_done = 1'b0;
    while (edges < 300 && !seen_done) begin
      if (done) begin
        seen_done = 1'b1;
        check("done_key_count", 64'(idx), 64'd16);
        if (!rand_ready) check("done_latency_edges", 64'(edges), 64'd17);
        check("fin_busy",   64'(busy),         64'd1);
        check("fin_valid",  64'(subkey_valid), 64'd0);
        check("fin_subkey", 64'(subkey),       64'd0);
        start = poke;
      end else begin
        check("run_valid",  64'(subkey_valid), 64'd1);
        check("run_busy",   64'(busy),         64'd1);
        check("run_subkey", 64'(subkey),       64'(exp_key(mode, dec, idx)));
        check("run_round",  64'(round),        64'(idx & 15));
        if (rand_ready) subkey_ready = 1'($urandom_range(0, 1));
        if (poke) start = 1'($urandom_range(0, 1));
        hs = subkey_valid && subkey_ready;
        @(negedge clk);
        edges++;
        if (hs) idx++;
      end
    end
    if (!seen_done) check("done_timeout", 64'd0, 64'd1);
    @(negedge clk);
    start = 1'b0;
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_done", 64'(done), 64'd0);
    subkey_ready = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    key_in = '0;
    subkey_ready = 1'b0;
`ifdef DES_KEYSCHED_DECRYPT_EN
    decrypt = 1'b0;
`endif
    #1;
    check_outputs_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_sched(KEY, 0, 1'b0, 1'b0, 1'b0);
    run_sched(KEY, 0, 1'b0, 1'b1, 1'b0);
    run_sched(KEY, 0, 1'b0, 1'b0, 1'b1);

    // Abort a schedule right after the round-7 handshake.
    @(negedge clk);
    key_in = KEY;
    start = 1'b1;
    subkey_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && round != 4'd8; i++) @(negedge clk);
    check("mid_round_before_reset", 64'(round), 64'd8);
    #2 rst_n = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_sched(KEY, 0, 1'b0, 1'b0, 1'b0);

    run_sched(56'h0, 1, 1'b0, 1'b0, 1'b0);
    run_sched({56{1'b1}}, 2, 1'b0, 1'b0, 1'b0);

`ifdef DES_KEYSCHED_DECRYPT_EN
    run_sched(KEY, 0, 1'b1, 1'b0, 1'b0);
    run_sched(KEY, 0, 1'b1, 1'b1, 1'b0);
    run_sched(KEY, 0, 1'b0, 1'b0, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
